countermod_n: RTL and testbench

Parametrised modulo-N counter, the general counter for the lab datapath. It supports up, down, bounce (ping-pong) and hold modes, synchronous clear and load, and a count enable. A combinational terminal-count output allows a cascade of instances, for example for seconds/minutes displays. A registered wrap pulse and a load-error pulse feed control logic.

---
 rtl/countermod_pkg.sv | 16 +
 rtl/countermod_dir_fsm.sv | 50 +++++
 rtl/countermod_n.sv | 124 ++++++++++++
 tb/tb_countermod_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/countermod_pkg.sv
// Shared types for the modulo-N counter: count modes and bounce direction states.
package countermod_pkg;

  typedef enum logic [1:0] {
    UP     = 2'b00,
    DOWN   = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  typedef enum logic {
    DOWN_S = 1'b0,
    UP_S   = 1'b1
  } dir_state_t;

endpackage

// File: rtl/countermod_dir_fsm.sv
// Bounce direction FSM: holds the ping-pong direction and flags a reversal at a terminal.
// The direction register updates on the clock edge; next_dir/reverse are combinational. There is no backpressure.
module countermod_dir_fsm
  import countermod_pkg::*;
#(
  parameter  int MODULUS = 7,
  localparam int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] value,
  output dir_state_t       dir,
  output dir_state_t       next_dir,
  output logic             reverse
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  dir_state_t dir_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir <= UP_S;
    end else begin
      dir <= dir_d;
    end
  end

  // Clear re-arms upward; a load leaves the stored direction alone.
  always_comb begin : next_state
    dir_d = dir;
    if (clear) begin
      dir_d = UP_S;
    end else if (!load && reverse) begin
      dir_d = dir_state_t'(~dir);
    end
  end

  always_comb begin : outputs
    reverse  = enable && (mode == BOUNCE) &&
               (((dir == UP_S) && (value == LAST)) ||
                ((dir == DOWN_S) && (value == '0)));
    next_dir = reverse ? dir_state_t'(~dir) : dir;
  end

endmodule

// File: rtl/countermod_n.sv
// Modulo-N up/down/bounce/hold counter with cascadable combinational tc and registered wrap/load_err pulses.
// value, dir, wrap and load_err are registered (one-edge update); tc has zero latency. There is no backpressure.
module countermod_n
  import countermod_pkg::*;
#(
  parameter  int MODULUS = 7,
  localparam int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  mode_t            mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             dir,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so MODULUS itself is representable when it is a power of two.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  dir_state_t       dir_q;
  dir_state_t       next_dir;
  logic             reverse;
  logic [WIDTH:0]   value_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic [WIDTH-1:0] value_d;
  logic             wrap_d;
  logic             load_err_d;
  logic             at_term;

  countermod_dir_fsm #(
    .MODULUS(MODULUS)
  ) u_dir_fsm (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .load    (load),
    .enable  (enable),
    .mode    (mode),
    .value   (value),
    .dir     (dir_q),
    .next_dir(next_dir),
    .reverse (reverse)
  );

  assign value_x = {1'b0, value};
  assign inc_x   = value_x + ONE_X;
  assign dec_x   = value_x - ONE_X;

  always_comb begin
    value_d    = value;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      if ({1'b0, load_value} < MOD_X) begin
        value_d = load_value;
      end else begin
        value_d    = LAST;
        load_err_d = 1'b1;
      end
    end else if (enable) begin
      case (mode)
        UP: begin
          if (value == LAST) begin
            value_d = '0;
            wrap_d  = 1'b1;
          end else begin
            value_d = inc_x[WIDTH-1:0];
          end
        end
        DOWN: begin
          if (value == '0) begin
            value_d = LAST;
            wrap_d  = 1'b1;
          end else begin
            value_d = dec_x[WIDTH-1:0];
          end
        end
        // Step in the post-reversal direction so a terminal bounces back in one edge.
        BOUNCE: begin
          value_d = (next_dir == UP_S) ? inc_x[WIDTH-1:0] : dec_x[WIDTH-1:0];
          wrap_d  = reverse;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    case (mode)
      UP:      at_term = (value == LAST);
      DOWN:    at_term = (value == '0);
      BOUNCE:  at_term = (dir_q == UP_S) ? (value == LAST) : (value == '0);
      default: at_term = 1'b0;
    endcase
  end

  assign tc  = enable & at_term;
  assign dir = dir_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      value    <= value_d;
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_countermod_n.sv
// Randomized scoreboard bench for countermod_n: four moduli in parallel plus a 10x6 cascade.
module tb_countermod_n;
  import countermod_pkg::*;

  typedef struct packed {
    logic [3:0][3:0] v;
    logic [3:0]      d;
    logic [3:0]      w;
    logic [3:0]      e;
    logic [3:0]      s0;
    logic [2:0]      s1;
    logic            cw0;
    logic            cw1;
  } exp_t;

  localparam int MODS [4] = '{7, 4, 2, 8};
  localparam int WB   [4] = '{3, 2, 1, 3};

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, ld = 1'b0, cen = 1'b0;
  mode_t      mode = UP;
  logic [3:0] lv = '0;

  logic [2:0] v7, v8;
  logic [1:0] v4;
  logic [0:0] v2;
  logic [3:0] ad, atc, aw, ae;
  logic [3:0] av [4];
  logic [3:0] s0v;
  logic [2:0] s1v;
  logic       c0dir, c0tc, c0w, c0e, c1dir, c1tc, c1w, c1e;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int   mv [4];
  bit   mdir [4];
  int   cn;

  always #5 clock = ~clock;

  countermod_n #(.MODULUS(7)) u7 (.clock(clock), .reset(rst_n), .enable(en), .mode(mode), .clear(clr),
    .load(ld), .load_value(lv[2:0]), .value(v7), .dir(ad[0]), .tc(atc[0]), .wrap(aw[0]), .load_err(ae[0]));
  countermod_n #(.MODULUS(4)) u4 (.clock(clock), .reset(rst_n), .enable(en), .mode(mode), .clear(clr),
    .load(ld), .load_value(lv[1:0]), .value(v4), .dir(ad[1]), .tc(atc[1]), .wrap(aw[1]), .load_err(ae[1]));
  countermod_n #(.MODULUS(2)) u2 (.clock(clock), .reset(rst_n), .enable(en), .mode(mode), .clear(clr),
    .load(ld), .load_value(lv[0:0]), .value(v2), .dir(ad[2]), .tc(atc[2]), .wrap(aw[2]), .load_err(ae[2]));
  countermod_n #(.MODULUS(8)) u8 (.clock(clock), .reset(rst_n), .enable(en), .mode(mode), .clear(clr),
    .load(ld), .load_value(lv[2:0]), .value(v8), .dir(ad[3]), .tc(atc[3]), .wrap(aw[3]), .load_err(ae[3]));

  countermod_n #(.MODULUS(10)) uc0 (.clock(clock), .reset(rst_n), .enable(cen), .mode(UP), .clear(1'b0),
    .load(1'b0), .load_value(4'd0), .value(s0v), .dir(c0dir), .tc(c0tc), .wrap(c0w), .load_err(c0e));
  countermod_n #(.MODULUS(6)) uc1 (.clock(clock), .reset(rst_n), .enable(c0tc), .mode(UP), .clear(1'b0),
    .load(1'b0), .load_value(3'd0), .value(s1v), .dir(c1dir), .tc(c1tc), .wrap(c1w), .load_err(c1e));

  assign av[0] = 4'(v7);
  assign av[1] = 4'(v4);
  assign av[2] = 4'(v2);
  assign av[3] = 4'(v8);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k]   = 0;
      mdir[k] = 1'b1;
    end
    cn = 0;
  endtask

  // Entered at a falling edge: drive, check tc, advance the model, queue the post-edge expectation.
  task automatic cycle(input bit e_, input mode_t m_, input bit c_, input bit l_,
                       input logic [3:0] lv_, input bit ce_);
    exp_t x;
    int   m, term, lvk;
    bit   rev, w, er;
    en = e_; mode = m_; clr = c_; ld = l_; lv = lv_; cen = ce_;
    #1;
    x = '0;
    for (int k = 0; k < 4; k++) begin
      m = MODS[k];
      term = (m_ == UP) ? m - 1 : (m_ == DOWN) ? 0 : (mdir[k] ? m - 1 : 0);
      chk($sformatf("tc[M=%0d]", m), int'(atc[k]), int'(e_ && m_ != HOLD && mv[k] == term));
      w = 1'b0;
      er = 1'b0;
      if (!rst_n || c_) begin
        mv[k] = 0;
        mdir[k] = 1'b1;
      end else if (l_) begin
        lvk = int'(lv_) % (1 << WB[k]);
        if (lvk < m) mv[k] = lvk;
        else begin
          mv[k] = m - 1;
          er = 1'b1;
        end
      end else if (e_ && m_ == UP) begin
        w = (mv[k] == m - 1);
        mv[k] = (mv[k] + 1) % m;
      end else if (e_ && m_ == DOWN) begin
        w = (mv[k] == 0);
        mv[k] = (mv[k] + m - 1) % m;
      end else if (e_ && m_ == BOUNCE) begin
        rev = (mdir[k] && mv[k] == m - 1) || (!mdir[k] && mv[k] == 0);
        if (rev) mdir[k] = !mdir[k];
        mv[k] = mdir[k] ? mv[k] + 1 : mv[k] - 1;
        w = rev;
      end
      x.v[k] = 4'(mv[k]);
      x.d[k] = mdir[k];
      x.w[k] = w;
      x.e[k] = er;
    end
    chk("tc[cascade0]", int'(c0tc), int'(ce_ && (cn % 10 == 9)));
    chk("tc[cascade1]", int'(c1tc), int'(ce_ && cn == 59));
    if (!rst_n) begin
      cn = 0;
    end else begin
      x.cw0 = ce_ && (cn % 10 == 9);
      x.cw1 = ce_ && (cn == 59);
      if (ce_) cn = (cn + 1) % 60;
    end
    x.s0 = 4'(cn % 10);
    x.s1 = 3'(cn / 10);
    sb.push_back(x);
    @(negedge clock);
  endtask

  // Monitor: every rising edge is an output beat; compare against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("value[M=%0d]", MODS[k]), int'(av[k]), int'(x.v[k]));
          chk($sformatf("dir[M=%0d]", MODS[k]), int'(ad[k]), int'(x.d[k]));
          chk($sformatf("wrap[M=%0d]", MODS[k]), int'(aw[k]), int'(x.w[k]));
          chk($sformatf("load_err[M=%0d]", MODS[k]), int'(ae[k]), int'(x.e[k]));
        end
        chk("cascade stage0", int'(s0v), int'(x.s0));
        chk("cascade stage1", int'(s1v), int'(x.s1));
        chk("cascade wrap0", int'(c0w), int'(x.cw0));
        chk("cascade wrap1", int'(c1w), int'(x.cw1));
        chk("cascade dir/err", int'({c0dir, c1dir, c0e, c1e}), 4'b1100);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s value[M=%0d]", tag, MODS[k]), int'(av[k]), 0);
      chk($sformatf("%s dir[M=%0d]", tag, MODS[k]), int'(ad[k]), 1);
      chk($sformatf("%s pulses[M=%0d]", tag, MODS[k]), int'({aw[k], ae[k]}), 0);
    end
    chk({tag, " cascade"}, int'({s1v, s0v}), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    rst_n = 1'b1;

    repeat (16) cycle(1, UP, 0, 0, 4'd0, 1);
    cycle(0, UP, 1, 0, 4'd0, 1);
    repeat (16) cycle(1, DOWN, 0, 0, 4'd0, 1);
    cycle(0, UP, 1, 0, 4'd0, 0);
    repeat (16) cycle(1, BOUNCE, 0, 0, 4'd0, 1);
    repeat (3) cycle(1, HOLD, 0, 0, 4'd0, 1);

    cycle(1, UP, 0, 1, 4'd5, 0);
    cycle(1, UP, 0, 0, 4'd0, 0);
    cycle(0, UP, 0, 1, 4'd7, 0);
    cycle(0, UP, 0, 1, 4'd15, 0);
    cycle(1, UP, 0, 0, 4'd0, 0);
    cycle(1, UP, 1, 1, 4'd3, 0);
    cycle(1, BOUNCE, 0, 1, 4'd0, 0);
    repeat (4) cycle(1, BOUNCE, 0, 0, 4'd0, 0);

    repeat (400)
      cycle($urandom_range(0, 3) != 0, mode_t'($urandom_range(0, 3)), $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);

    // Asynchronous reset between edges while counting up.
    cycle(0, UP, 1, 0, 4'd0, 1);
    repeat (4) cycle(1, UP, 0, 0, 4'd0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async reset");
    model_reset();
    @(negedge clock);
    repeat (2) cycle(1, UP, 0, 0, 4'd0, 1);
    rst_n = 1'b1;

    repeat (60)
      cycle($urandom_range(0, 1) == 1, mode_t'($urandom_range(0, 3)), 0,
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 1);
    repeat (3) cycle(1, UP, 0, 0, 4'd0, 0);

    @(posedge clock);
    #2;
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
